// File: rtl/mdu_pkg.sv
// mdu_pkg: shared constants and types for the iterative multiply/divide unit.
//   MDU_WIDTH   - default operand and HI/LO width
//   ITER_COUNT  - number of CALC iterations per operation
//   CNT_W       - width of the iteration counter
//   mdu_op_e    - MULT / MULTU / DIV / DIVU encoding of the op field
//   mdu_state_e - control FSM states
package mdu_pkg;

    localparam int MDU_WIDTH  = 32;
    localparam int ITER_COUNT = 32;
    localparam int CNT_W      = 6;

    typedef enum logic [1:0] {
        MDU_MULT  = 2'b00,
        MDU_MULTU = 2'b01,
        MDU_DIV   = 2'b10,
        MDU_DIVU  = 2'b11
    } mdu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CALC  = 2'd1,
        ST_FIXUP = 2'd2,
        ST_DONE  = 2'd3
    } mdu_state_e;

    // The upper op bit selects the divider, the lower bit selects unsigned.
    function automatic logic is_div_op(input logic [1:0] op);
        return op[1];
    endfunction

    function automatic logic is_signed_op(input logic [1:0] op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// mult_div_unit_if: request/result bundle between the datapath and the MDU.
//   start, op, rs_val, rt_val, mthi, mtlo : requester -> MDU
//   busy, done, div_zero, hi, lo          : MDU -> requester
// master: the requester side (control unit / testbench); slave: the MDU.
interface mult_div_unit_if
    import mdu_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH
) ();

    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] rs_val;
    logic [WIDTH-1:0] rt_val;
    logic             mthi;
    logic             mtlo;
    logic             busy;
    logic             done;
    logic             div_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, rs_val, rt_val, mthi, mtlo,
        input  busy, done, div_zero, hi, lo
    );

    modport slave (
        input  start, op, rs_val, rt_val, mthi, mtlo,
        output busy, done, div_zero, hi, lo
    );

endinterface

// File: rtl/mdu_iter_step.sv
// mdu_iter_step: one combinational iteration of the MDU datapath.
//   is_div_i  - 0: radix-2 shift-add multiply step, 1: restoring divide step
//   acc_i     - 2*WIDTH accumulator
//                 multiply: {partial product high, remaining multiplier bits}
//                 divide:   {partial remainder, dividend/quotient bits}
//   operand_i - multiplicand magnitude (multiply) or divisor magnitude (divide)
//   acc_o     - accumulator after this iteration
module mdu_iter_step
    import mdu_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH
) (
    input  logic               is_div_i,
    input  logic [2*WIDTH-1:0] acc_i,
    input  logic [WIDTH-1:0]   operand_i,
    output logic [2*WIDTH-1:0] acc_o
);

    logic [WIDTH:0]   add_sum_s;
    logic [2*WIDTH:0] shl_s;
    logic [WIDTH:0]   trial_s;

    // Single shift-add or shift-subtract iteration.
    always_comb begin
        // Multiply: add the multiplicand to the high half when the current
        // multiplier LSB is set, then shift the whole accumulator right.
        add_sum_s = {1'b0, acc_i[2*WIDTH-1:WIDTH]}
                  + (acc_i[0] ? {1'b0, operand_i} : {(WIDTH+1){1'b0}});
        // Divide: shift left, then trial-subtract the divisor from the
        // WIDTH+1-bit partial remainder; bit WIDTH of the trial is its sign.
        shl_s   = {acc_i, 1'b0};
        trial_s = shl_s[2*WIDTH:WIDTH] - {1'b0, operand_i};
        if (is_div_i) begin
            if (!trial_s[WIDTH]) begin
                acc_o = {trial_s[WIDTH-1:0], shl_s[WIDTH-1:1], 1'b1};
            end else begin
                acc_o = shl_s[2*WIDTH-1:0];
            end
        end else begin
            acc_o = {add_sum_s, acc_i[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative MULT/MULTU/DIV/DIVU unit producing the HI/LO pair.
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset; aborts any operation in flight
//   bus   - mult_div_unit_if.slave: start/op/rs_val/rt_val/mthi/mtlo in,
//           busy/done/div_zero/hi/lo out (all outputs registered)
// Build option: define MDU_DIV_EN to include the divider. Without it,
// DIV/DIVU complete the cycle after launch with HI/LO unchanged.
// Magnitudes are iterated for WIDTH cycles, then signs are applied in FIXUP,
// so HI/LO only ever change on FIXUP, divide-by-zero launch, or MTHI/MTLO.
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH
) (
    input  logic              clk,
    input  logic              rst_n,
    mult_div_unit_if.slave    bus
);

    mdu_state_e         state_q, state_d;
    logic               op_div_q, op_div_d;
    logic               neg_res_q, neg_res_d;
    logic               neg_rem_q, neg_rem_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   operand_q, operand_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               div_zero_q, div_zero_d;

    logic               launch_s;
    logic               signed_s;
    logic               div_req_s;
    logic               step_div_s;
    logic [WIDTH-1:0]   rs_mag_s;
    logic [WIDTH-1:0]   rt_mag_s;
    logic [2*WIDTH-1:0] step_acc_s;
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0]   quot_s;
    logic [WIDTH-1:0]   rem_s;

`ifdef MDU_DIV_EN
    assign step_div_s = op_div_q;
`else
    assign step_div_s = 1'b0;
`endif

    mdu_iter_step #(.WIDTH(WIDTH)) u_step (
        .is_div_i  (step_div_s),
        .acc_i     (acc_q),
        .operand_i (operand_q),
        .acc_o     (step_acc_s)
    );

    // Next-state, datapath and output computation.
    always_comb begin
        state_d    = state_q;
        op_div_d   = op_div_q;
        neg_res_d  = neg_res_q;
        neg_rem_d  = neg_rem_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        operand_d  = operand_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        div_zero_d = div_zero_q;

        // DONE also accepts start so back-to-back operations lose no cycle.
        launch_s  = bus.start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
        signed_s  = is_signed_op(bus.op);
        div_req_s = is_div_op(bus.op);
        rs_mag_s  = (signed_s && bus.rs_val[WIDTH-1]) ? ({WIDTH{1'b0}} - bus.rs_val) : bus.rs_val;
        rt_mag_s  = (signed_s && bus.rt_val[WIDTH-1]) ? ({WIDTH{1'b0}} - bus.rt_val) : bus.rt_val;
        prod_s    = neg_res_q ? ({(2*WIDTH){1'b0}} - acc_q) : acc_q;
        quot_s    = neg_res_q ? ({WIDTH{1'b0}} - acc_q[WIDTH-1:0]) : acc_q[WIDTH-1:0];
        rem_s     = neg_rem_q ? ({WIDTH{1'b0}} - acc_q[2*WIDTH-1:WIDTH]) : acc_q[2*WIDTH-1:WIDTH];

        if (launch_s) begin
            op_div_d   = div_req_s;
            cnt_d      = {CNT_W{1'b0}};
            div_zero_d = 1'b0;
            neg_res_d  = signed_s & (bus.rs_val[WIDTH-1] ^ bus.rt_val[WIDTH-1]);
            neg_rem_d  = signed_s & bus.rs_val[WIDTH-1];
            if (div_req_s) begin
`ifdef MDU_DIV_EN
                if (bus.rt_val == {WIDTH{1'b0}}) begin
                    state_d    = ST_DONE;
                    hi_d       = bus.rs_val;
                    lo_d       = {WIDTH{1'b1}};
                    div_zero_d = 1'b1;
                end else begin
                    acc_d     = {{WIDTH{1'b0}}, rs_mag_s};
                    operand_d = rt_mag_s;
                    state_d   = ST_CALC;
                end
`else
                state_d = ST_DONE;
`endif
            end else begin
                acc_d     = {{WIDTH{1'b0}}, rt_mag_s};
                operand_d = rs_mag_s;
                state_d   = ST_CALC;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.mthi) begin
                        hi_d = bus.rs_val;
                    end else begin
                        hi_d = hi_q;
                    end
                    if (bus.mtlo) begin
                        lo_d = bus.rs_val;
                    end else begin
                        lo_d = lo_q;
                    end
                end
                ST_CALC: begin
                    acc_d = step_acc_s;
                    if (cnt_q == CNT_W'(ITER_COUNT - 1)) begin
                        state_d = ST_FIXUP;
                    end else begin
                        cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                ST_FIXUP: begin
                    if (op_div_q) begin
                        lo_d = quot_s;
                        hi_d = rem_s;
                    end else begin
                        hi_d = prod_s[2*WIDTH-1:WIDTH];
                        lo_d = prod_s[WIDTH-1:0];
                    end
                    state_d = ST_DONE;
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        busy_d = (state_d == ST_CALC) || (state_d == ST_FIXUP);
        done_d = (state_d == ST_DONE);
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            op_div_q   <= 1'b0;
            neg_res_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            cnt_q      <= {CNT_W{1'b0}};
            acc_q      <= {(2*WIDTH){1'b0}};
            operand_q  <= {WIDTH{1'b0}};
            hi_q       <= {WIDTH{1'b0}};
            lo_q       <= {WIDTH{1'b0}};
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_div_q   <= op_div_d;
            neg_res_q  <= neg_res_d;
            neg_rem_q  <= neg_rem_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            operand_q  <= operand_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            div_zero_q <= div_zero_d;
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.div_zero = div_zero_q;
    assign bus.hi       = hi_q;
    assign bus.lo       = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: directed plus randomized test of mult_div_unit against a
// plain-arithmetic model of HI/LO, div_zero and completion latency.
module tb_mult_div_unit;
    import mdu_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    mult_div_unit_if #(.WIDTH(32)) bus ();

    mult_div_unit #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_hi   = 32'd0;
    logic [31:0] exp_lo   = 32'd0;
    logic        exp_dz   = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: 64-bit arithmetic; returns completion latency in cycles.
    task automatic model_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                            output int lat);
        longint      sa;
        longint      sb;
        logic [63:0] p;
        exp_dz = 1'b0;
        if (!op[1]) begin
            if (op == 2'b00) begin
                sa = longint'($signed(a));
                sb = longint'($signed(b));
                p  = 64'(sa * sb);
            end else begin
                p = {32'd0, a} * {32'd0, b};
            end
            exp_hi = p[63:32];
            exp_lo = p[31:0];
            lat    = 34;
        end else begin
`ifdef MDU_DIV_EN
            if (b == 32'd0) begin
                exp_hi = a;
                exp_lo = 32'hFFFF_FFFF;
                exp_dz = 1'b1;
                lat    = 1;
            end else begin
                longint q;
                longint r;
                if (op == 2'b10) begin
                    sa = longint'($signed(a));
                    sb = longint'($signed(b));
                end else begin
                    sa = longint'({32'd0, a});
                    sb = longint'({32'd0, b});
                end
                q      = sa / sb;
                r      = sa % sb;
                exp_lo = q[31:0];
                exp_hi = r[31:0];
                lat    = 34;
            end
`else
            lat = 1;
`endif
        end
    endtask

    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic with_mt, input logic disturb);
        int          lat_exp;
        int          lat_obs;
        logic [31:0] hi0;
        logic [31:0] lo0;
        bit          busy_bad;
        bit          mid_bad;
        logic        s_done;
        logic        s_busy;
        logic [31:0] s_hi;
        logic [31:0] s_lo;
        hi0 = exp_hi;
        lo0 = exp_lo;
        model_op(op, a, b, lat_exp);
        @(negedge clk);
        bus.start  = 1'b1;
        bus.op     = op;
        bus.rs_val = a;
        bus.rt_val = b;
        bus.mthi   = with_mt;
        bus.mtlo   = with_mt;
        lat_obs  = 0;
        busy_bad = 1'b0;
        mid_bad  = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            s_done = bus.done;
            s_busy = bus.busy;
            s_hi   = bus.hi;
            s_lo   = bus.lo;
            if (k == 1) begin
                bus.start  = 1'b0;
                bus.mthi   = 1'b0;
                bus.mtlo   = 1'b0;
                bus.rs_val = $urandom;
                bus.rt_val = $urandom;
            end
            if (disturb && k == 10) begin
                bus.start  = 1'b1;
                bus.mtlo   = 1'b1;
                bus.mthi   = 1'b1;
                bus.op     = 2'($urandom_range(0, 3));
                bus.rs_val = 32'hDEAD_BEEF;
            end
            if (disturb && k == 11) begin
                bus.start = 1'b0;
                bus.mtlo  = 1'b0;
                bus.mthi  = 1'b0;
            end
            if (s_busy !== (k < lat_exp)) busy_bad = 1'b1;
            if (s_done === 1'b1) begin
                lat_obs = k;
                break;
            end
            if (s_hi !== hi0 || s_lo !== lo0) mid_bad = 1'b1;
        end
        check({tag, " latency"}, 64'(lat_obs), 64'(lat_exp));
        check({tag, " busy_profile"}, 64'(busy_bad), 64'd0);
        check({tag, " hilo_hidden"}, 64'(mid_bad), 64'd0);
        check({tag, " hi"}, 64'(bus.hi), 64'(exp_hi));
        check({tag, " lo"}, 64'(bus.lo), 64'(exp_lo));
        check({tag, " div_zero"}, 64'(bus.div_zero), 64'(exp_dz));
        @(negedge clk);
        check({tag, " done_pulse"}, 64'(bus.done), 64'd0);
    endtask

    task automatic mt_write(input string tag, input logic h, input logic l, input logic [31:0] v);
        @(negedge clk);
        bus.mthi   = h;
        bus.mtlo   = l;
        bus.rs_val = v;
        bus.start  = 1'b0;
        @(negedge clk);
        bus.mthi = 1'b0;
        bus.mtlo = 1'b0;
        if (h) exp_hi = v;
        if (l) exp_lo = v;
        check({tag, " hi"}, 64'(bus.hi), 64'(exp_hi));
        check({tag, " lo"}, 64'(bus.lo), 64'(exp_lo));
        check({tag, " busy"}, 64'(bus.busy), 64'd0);
    endtask

    initial begin
        logic [1:0]  r_op;
        logic [31:0] r_a;
        logic [31:0] r_b;
        bus.start  = 1'b0;
        bus.op     = 2'b00;
        bus.rs_val = 32'd0;
        bus.rt_val = 32'd0;
        bus.mthi   = 1'b0;
        bus.mtlo   = 1'b0;
        repeat (3) @(negedge clk);
        check("reset busy", 64'(bus.busy), 64'd0);
        check("reset done", 64'(bus.done), 64'd0);
        check("reset div_zero", 64'(bus.div_zero), 64'd0);
        check("reset hi", 64'(bus.hi), 64'd0);
        check("reset lo", 64'(bus.lo), 64'd0);
        rst_n = 1'b1;

        run_op("multu_max", MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
        check("multu_max hi_const", 64'(bus.hi), 64'h0000_0000_FFFF_FFFE);
        check("multu_max lo_const", 64'(bus.lo), 64'h0000_0000_0000_0001);
        run_op("mult_neg", MDU_MULT, 32'hFFFF_FFFD, 32'd7, 1'b0, 1'b0);
        check("mult_neg hi_const", 64'(bus.hi), 64'h0000_0000_FFFF_FFFF);
        check("mult_neg lo_const", 64'(bus.lo), 64'h0000_0000_FFFF_FFEB);

        run_op("div_ovf", MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
`ifdef MDU_DIV_EN
        check("div_ovf lo_const", 64'(bus.lo), 64'h0000_0000_8000_0000);
`endif
        run_op("div_neg", MDU_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
`ifdef MDU_DIV_EN
        check("div_neg lo_const", 64'(bus.lo), 64'h0000_0000_FFFF_FFFD);
`endif
        run_op("divu_small", MDU_DIVU, 32'd100, 32'd7, 1'b0, 1'b0);
        run_op("div_zero", MDU_DIV, 32'd5, 32'd0, 1'b0, 1'b0);
        run_op("mult_after_dz", MDU_MULT, 32'd6, 32'd7, 1'b0, 1'b0);

        run_op("mult_disturb", MDU_MULT, 32'h0001_2345, 32'hFFFF_0001, 1'b0, 1'b1);
        mt_write("mthi_only", 1'b1, 1'b0, 32'h0000_1234);
        mt_write("mtlo_only", 1'b0, 1'b1, 32'hCAFE_0000);
        mt_write("mt_both", 1'b1, 1'b1, 32'h55AA_55AA);
        run_op("start_beats_mt", MDU_MULTU, 32'd3, 32'd5, 1'b1, 1'b0);

        // Reset in the middle of a multiply.
        @(negedge clk);
        bus.start  = 1'b1;
        bus.op     = MDU_MULT;
        bus.rs_val = 32'h7FFF_FFFF;
        bus.rt_val = 32'h7FFF_FFFF;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        #1;
        exp_hi = 32'd0;
        exp_lo = 32'd0;
        exp_dz = 1'b0;
        check("abort busy", 64'(bus.busy), 64'd0);
        check("abort done", 64'(bus.done), 64'd0);
        check("abort hi", 64'(bus.hi), 64'd0);
        check("abort lo", 64'(bus.lo), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op("divu_after_rst", MDU_DIVU, 32'd9, 32'd3, 1'b0, 1'b0);

        for (int i = 0; i < 20; i++) begin
            r_op = 2'($urandom_range(0, 3));
            r_a  = $urandom;
            r_b  = $urandom;
            if ($urandom_range(0, 5) == 0) r_b = 32'd0;
            if ($urandom_range(0, 3) == 0) r_b = 32'($urandom_range(1, 20));
            if ($urandom_range(0, 3) == 0) begin
                mt_write("rand_mt", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
            end
            run_op("rand_op", r_op, r_a, r_b, 1'($urandom_range(0, 1)), 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
